// File: rtl/lif_spike_rate_decoder.sv
// Spike-rate decoder: counts spikes over WINDOW enabled cycles and hands each result out over valid/ready.
// Optional inter-spike-interval measurement is built only when LIF_DEC_ISI_EN is defined.
module lif_spike_rate_decoder #(
   parameter int unsigned WINDOW = 256,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned ISI_W  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   output logic [CNT_W-1:0] rate_out,
   output logic             rate_sat,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic             dropped,
   output logic [ISI_W-1:0] isi_out,
   output logic             isi_valid
);

   localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_MAX - 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic             sat_acc_q, sat_acc_d;

   logic             inc;
   logic             win_close;
   logic             acc_hit;
   logic [CNT_W-1:0] acc_sum;
   logic             final_sat;

   out_state_e       state_q;
   logic [CNT_W-1:0] rate_q;
   logic             rate_sat_q;
   logic             rate_valid_q;
   logic             dropped_q;

   // The closing cycle's own spike is folded in through acc_sum/acc_hit.
   always_comb begin
      inc       = en & spike_in;
      win_close = en & (win_cnt_q == WIN_LAST);
      acc_hit   = inc & (acc_q >= CNT_TOP);
      acc_sum   = (inc && (acc_q != CNT_MAX)) ? acc_q + 1'b1 : acc_q;
      final_sat = sat_acc_q | acc_hit;

      win_cnt_d = win_cnt_q;
      acc_d     = acc_q;
      sat_acc_d = sat_acc_q;
      if (en) begin
         if (win_close) begin
            win_cnt_d = '0;
            acc_d     = '0;
            sat_acc_d = 1'b0;
         end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            acc_d     = acc_sum;
            sat_acc_d = final_sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt_q <= '0;
         acc_q     <= '0;
         sat_acc_q <= 1'b0;
      end else begin
         win_cnt_q <= win_cnt_d;
         acc_q     <= acc_d;
         sat_acc_q <= sat_acc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         rate_q       <= '0;
         rate_sat_q   <= 1'b0;
         rate_valid_q <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         dropped_q <= 1'b0;
         unique case (state_q)
            EMPTY: begin
               if (win_close) begin
                  rate_q       <= acc_sum;
                  rate_sat_q   <= final_sat;
                  rate_valid_q <= 1'b1;
                  state_q      <= FULL;
               end
            end
            FULL: begin
               if (win_close) begin
                  if (rate_ready) begin
                     rate_q     <= acc_sum;
                     rate_sat_q <= final_sat;
                  end else begin
                     dropped_q <= 1'b1;
                  end
               end else if (rate_ready) begin
                  rate_valid_q <= 1'b0;
                  state_q      <= EMPTY;
               end
            end
            default: begin
               rate_valid_q <= 1'b0;
               state_q      <= EMPTY;
            end
         endcase
      end
   end

   assign rate_out   = rate_q;
   assign rate_sat   = rate_sat_q;
   assign rate_valid = rate_valid_q;
   assign dropped    = dropped_q;

`ifdef LIF_DEC_ISI_EN
   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
   logic [ISI_W-1:0] isi_out_q, isi_out_d;
   logic             isi_valid_q, isi_valid_d;
   logic             armed_q, armed_d;
   logic [ISI_W-1:0] isi_next;

   // The counter restarts at 0 on a spike, so the interval is the count plus the spike cycle itself.
   always_comb begin
      isi_next    = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 1'b1;
      isi_cnt_d   = isi_cnt_q;
      isi_out_d   = isi_out_q;
      isi_valid_d = 1'b0;
      armed_d     = armed_q;
      if (en) begin
         if (spike_in) begin
            isi_cnt_d = '0;
            armed_d   = 1'b1;
            if (armed_q) begin
               isi_out_d   = isi_next;
               isi_valid_d = 1'b1;
            end
         end else begin
            isi_cnt_d = isi_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         isi_cnt_q   <= '0;
         isi_out_q   <= '0;
         isi_valid_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         isi_cnt_q   <= isi_cnt_d;
         isi_out_q   <= isi_out_d;
         isi_valid_q <= isi_valid_d;
         armed_q     <= armed_d;
      end
   end

   assign isi_out   = isi_out_q;
   assign isi_valid = isi_valid_q;
`else
   assign isi_out   = '0;
   assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// Bench for lif_spike_rate_decoder: directed scenarios with literal expectations plus a random run
// checked every cycle against a spike-counting model.
module tb_lif_spike_rate_decoder;

   localparam int WINDOW = 8;
   localparam int CNT_W  = 3;
   localparam int ISI_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int IMAX   = (1 << ISI_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             spike_in = 1'b0;
   logic             rate_ready = 1'b0;
   logic [CNT_W-1:0] rate_out;
   logic             rate_sat;
   logic             rate_valid;
   logic             dropped;
   logic [ISI_W-1:0] isi_out;
   logic             isi_valid;

   int n_cmp = 0;
   int n_mis = 0;

   lif_spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
      .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
      .rate_out(rate_out), .rate_sat(rate_sat), .rate_valid(rate_valid),
      .rate_ready(rate_ready), .dropped(dropped),
      .isi_out(isi_out), .isi_valid(isi_valid)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: counts enabled cycles and spikes as plain integers.
   bit m_started = 0;
   int m_pos, m_spk, m_t, m_last;
   bit m_full, m_sat, m_drop, m_isiv, m_armed;
   int m_rate, m_isi;
   int n;
   bit close;

   always @(posedge clk) begin
      if (rst) begin
         m_started = 1;
         m_pos = 0; m_spk = 0; m_t = 0; m_last = 0;
         m_full = 0; m_sat = 0; m_drop = 0; m_isiv = 0; m_armed = 0;
         m_rate = 0; m_isi = 0;
      end else if (m_started) begin
         close  = en && (m_pos == WINDOW - 1);
         n      = m_spk + ((en && spike_in) ? 1 : 0);
         m_drop = 0;
         m_isiv = 0;
         if (close) begin
            if (!m_full || rate_ready) begin
               m_rate = (n > CMAX) ? CMAX : n;
               m_sat  = (n >= CMAX);
               m_full = 1;
            end else begin
               m_drop = 1;
            end
         end else if (m_full && rate_ready) begin
            m_full = 0;
         end
         if (en) begin
            m_pos = close ? 0 : m_pos + 1;
            m_spk = close ? 0 : n;
            m_t++;
            if (spike_in) begin
               if (m_armed) begin
                  m_isi  = (m_t - m_last > IMAX) ? IMAX : m_t - m_last;
                  m_isiv = 1;
               end
               m_armed = 1;
               m_last  = m_t;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("rate_valid", int'(rate_valid), int'(m_full));
         check("rate_out", int'(rate_out), m_rate);
         check("rate_sat", int'(rate_sat), int'(m_sat));
         check("dropped", int'(dropped), int'(m_drop));
`ifdef LIF_DEC_ISI_EN
         check("isi_valid", int'(isi_valid), int'(m_isiv));
         check("isi_out", int'(isi_out), m_isi);
`else
         check("isi_valid", int'(isi_valid), 0);
         check("isi_out", int'(isi_out), 0);
`endif
      end
   end

   task automatic cyc(input bit e, input bit s, input bit r);
      en = e; spike_in = s; rate_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      check("reset rate_out", int'(rate_out), 0);
      check("reset rate_valid", int'(rate_valid), 0);
      check("reset dropped", int'(dropped), 0);
      check("reset isi_valid", int'(isi_valid), 0);

      // 1: four spikes, last one on the closing cycle
      for (int i = 0; i < WINDOW; i++) begin
         cyc(1, (i % 2) == 1, 1);
         if (i == WINDOW - 2) check("t1 valid before close", int'(rate_valid), 0);
      end
      check("t1 valid", int'(rate_valid), 1);
      check("t1 rate", int'(rate_out), 4);
      check("t1 sat", int'(rate_sat), 0);
      cyc(0, 0, 1);
      check("t1 valid drop", int'(rate_valid), 0);

      // 2: saturated window, then two spikes
      for (int i = 0; i < WINDOW; i++) cyc(1, 1, 1);
      check("t2 rate sat", int'(rate_out), CMAX);
      check("t2 sat", int'(rate_sat), 1);
      for (int i = 0; i < WINDOW; i++) cyc(1, i < 2, 1);
      check("t2 rate 2", int'(rate_out), 2);
      check("t2 sat clear", int'(rate_sat), 0);
      cyc(0, 0, 1);

      // 3: consumer stalled across two closes
      for (int i = 0; i < WINDOW; i++) cyc(1, i < 3, 0);
      check("t3 first", int'(rate_out), 3);
      for (int i = 0; i < WINDOW; i++) begin
         cyc(1, i < 5, 0);
         if (i < WINDOW - 1) check("t3 no early drop", int'(dropped), 0);
      end
      check("t3 dropped", int'(dropped), 1);
      check("t3 rate kept", int'(rate_out), 3);
      cyc(0, 0, 0);
      check("t3 drop pulse", int'(dropped), 0);
      check("t3 still valid", int'(rate_valid), 1);
      cyc(0, 0, 1);
      check("t3 valid drop", int'(rate_valid), 0);

      // 4: ready on the exact close cycle while full
      for (int i = 0; i < WINDOW; i++) cyc(1, i < 6, 0);
      for (int i = 0; i < WINDOW; i++) cyc(1, i == WINDOW - 1, i == WINDOW - 1);
      check("t4 rate", int'(rate_out), 1);
      check("t4 valid", int'(rate_valid), 1);
      check("t4 dropped", int'(dropped), 0);
      cyc(0, 0, 1);

      // 5: en low mid-window with spikes present
      for (int i = 0; i < 3; i++) cyc(1, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0);
      check("t5 not closed", int'(rate_valid), 0);
      cyc(1, 0, 0);
      check("t5 rate", int'(rate_out), 3);
      check("t5 valid", int'(rate_valid), 1);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0);
      rst = 1'b1;
      cyc(1, 1, 0);
      rst = 1'b0;
      check("t5 rst rate", int'(rate_out), 0);
      check("t5 rst valid", int'(rate_valid), 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 1);
      check("t5 no result", int'(rate_valid), 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0);
      check("t5 fresh window", int'(rate_valid), 1);
      check("t5 partial discarded", int'(rate_out), 0);

      // 6: spikes at en-cycles 2, 5, 20
      do_reset();
      for (int i = 0; i <= 20; i++) begin
         cyc(1, (i == 2) || (i == 5) || (i == 20), 1);
`ifdef LIF_DEC_ISI_EN
         if (i == 2) check("t6 arm only", int'(isi_valid), 0);
         if (i == 5) begin
            check("t6 isi valid 1", int'(isi_valid), 1);
            check("t6 isi 3", int'(isi_out), 3);
         end
         if (i == 6) check("t6 isi pulse", int'(isi_valid), 0);
         if (i == 20) begin
            check("t6 isi valid 2", int'(isi_valid), 1);
            check("t6 isi sat", int'(isi_out), IMAX);
         end
`else
         if (i == 5 || i == 20) check("t6 isi off", int'(isi_valid), 0);
`endif
      end

      // random run against the model
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      end
      rst = 1'b0;
      cyc(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
